// File: rtl/as_pack.sv
// Shared constants and types for the as_* UART blocks.
// Bit timing is expressed in clk cycles: br_cnt_max+1 cycles per bit.
package as_pack;

  localparam int unsigned br_cnt_max     = 9;
  localparam int unsigned br2_cnt_max    = 4;
  localparam int unsigned uart_data_bits = 8;
  localparam int unsigned br_cnt_w       = $clog2(br_cnt_max + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/as_br.sv
// Baud-rate generator: free-running bit counter, restartable by start_i.
// br_o marks the end of a bit period, br2_o the half-bit point.
module as_br
  import as_pack::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic br_o,
  output logic br2_o
);

  logic [br_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (start_i || (cnt_q == br_cnt_w'(br_cnt_max))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strobes are suppressed while restarting so a stale count cannot fire.
  assign br_o  = !start_i && (cnt_q == br_cnt_w'(br_cnt_max));
  assign br2_o = !start_i && (cnt_q == br_cnt_w'(br2_cnt_max));

endmodule

// File: rtl/as_uart_rx.sv
// 8N1 UART receiver: synchronised start-edge detect, mid-bit sampling via
// as_br, and a one-entry holding register with framing/overrun status.
module as_uart_rx
  import as_pack::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rxd_i,
  input  logic                      rd_i,
  output logic [uart_data_bits-1:0] data_o,
  output logic                      valid_o,
  output logic                      fe_o,
  output logic                      ov_o,
  output logic                      busy_o
);

  // Handshake: valid_o high means data_o is unread; rd_i while valid_o
  // consumes it (valid_o/fe_o/ov_o drop next cycle). A delivery in the same
  // cycle as rd_i wins: the new byte loads and valid_o stays high.

  localparam logic [2:0] last_bit = 3'(uart_data_bits - 1);

  rx_state_t                 state_q, state_d;
  logic                      rxd_meta_q, rxd_s_q, rxd_d_q;
  logic                      start_q, start_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [uart_data_bits-1:0] shreg_q, shreg_d;
  logic [uart_data_bits-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
  logic                      ov_q, ov_d;
  logic                      deliver;
  logic                      start_s;
  logic                      br2_s;

  assign start_s = start_q;

  as_br u_br (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_s),
    .br_o    (),
    .br2_o   (br2_s)
  );

  // Synchroniser and edge-detect delay idle high so reset never looks like a start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
    deliver   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (rxd_d_q && !rxd_s_q) begin
          start_d = 1'b1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (br2_s) begin
          if (!rxd_s_q) begin
            bit_cnt_d = 3'd0;
            state_d   = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (br2_s) begin
          shreg_d   = {rxd_s_q, shreg_q[uart_data_bits-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == last_bit) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (br2_s) begin
          deliver = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (rd_i && valid_q) begin
      valid_d = 1'b0;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
    end

    if (deliver) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      fe_d    = ~rxd_s_q;
      ov_d    = ov_d | (valid_q & ~rd_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RX_IDLE;
      start_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign fe_o    = fe_q;
  assign ov_o    = ov_q;
  assign busy_o  = (state_q != RX_IDLE);

endmodule

// File: tb/tb_as_uart_rx.sv
// Directed bench for as_uart_rx at 10 clk per bit; expected values are
// hand-computed per frame and compared on the falling clock edge.
module tb_as_uart_rx;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       ov;
  logic       busy;

  int n_vec;
  int n_err;
  int start_cnt;
  int start_ref;

  as_uart_rx dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .rxd_i   (rxd),
    .rd_i    (rd),
    .data_o  (data),
    .valid_o (valid),
    .fe_o    (fe),
    .ov_o    (ov),
    .busy_o  (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.start_s === 1'b1) start_cnt++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (10) @(posedge clk);
    end
    #1 rxd = stop_bit;
    repeat (10) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_data, input logic e_valid,
                           input logic e_fe, input logic e_ov, input logic e_busy);
    @(negedge clk);
    check_eq({tag, "_data"},  32'(data),  32'(e_data));
    check_eq({tag, "_valid"}, 32'(valid), 32'(e_valid));
    check_eq({tag, "_fe"},    32'(fe),    32'(e_fe));
    check_eq({tag, "_ov"},    32'(ov),    32'(e_ov));
    check_eq({tag, "_busy"},  32'(busy),  32'(e_busy));
  endtask

  initial begin
    n_vec = 0; n_err = 0; start_cnt = 0;
    rst = 1'b1; rxd = 1'b1; rd = 1'b0;
    repeat (3) @(posedge clk);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // plain frame
    start_ref = start_cnt;
    send_frame(8'hA5, 1'b1);
    check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("a5_start_pulses", 32'(start_cnt - start_ref), 32'd1);
    pulse_rd();
    check_out("a5_rd", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3-clk glitch: start pulse issued, frame abandoned at first mid-bit sample
    start_ref = start_cnt;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    @(negedge clk);
    check_eq("glitch_busy_mid", 32'(busy), 32'd1);
    repeat (12) @(posedge clk);
    check_out("glitch_end", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("glitch_start_pulses", 32'(start_cnt - start_ref), 32'd1);
    repeat (5) @(posedge clk);

    // framing error
    send_frame(8'h3C, 1'b0);
    check_out("3c_fe", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_rd();
    check_out("3c_rd", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_out("ovr", 8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_rd();
    check_out("ovr_rd", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // rd in the delivery cycle of the second byte: falling edge at P0+1,
    // mid-stop sample lands on P99, so rd is held over (P98, P99]
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (99) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    check_out("rd_same", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // reset during bit 4 of 0xFF (bit 4 spans P50..P60)
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (56) @(posedge clk);
        #1 rst = 1'b1;
        check_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    check_out("post_rst_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1);
    check_out("5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/as_uart_rx.md
# as_uart_rx

UART receiver for 8N1 serial frames, the receive-side counterpart of the UART transmit path in ip_uart. It synchronises the asynchronous rxd_i line and detects the start bit. It restarts the shared baud-rate generator (as_br) on that edge so that its half-bit tick lands mid-bit, then samples 8 data bits LSB-first and the stop bit. The received byte is delivered through a one-entry holding register with a read-acknowledge handshake, plus framing-error and overrun status.

## Interface
- no module parameters; bit timing comes from as_pack constants br_cnt_max (clk cycles per bit − 1) and br2_cnt_max (half-bit point, 0 < br2_cnt_max < br_cnt_max)
- uart_data_bits, as_pack, 8: data bits per frame
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- rxd_i  in  1  serial line, idle high, asynchronous to clk_i
- rd_i  in  1  read acknowledge; consumes the held byte and clears status
- data_o  out  8  last received byte
- valid_o  out  1  data_o holds an unread byte
- fe_o  out  1  framing error: stop bit of the byte in data_o sampled 0
- ov_o  out  1  overrun: a byte was overwritten before being read
- busy_o  out  1  frame reception in progress (state ≠ IDLE)

## Operation
- rxd_i passes through a 2-FF synchroniser (rxd_s) and one delay flop (rxd_d); all three reset to 1.
- Falling edge = rxd_d==1 && rxd_s==0, evaluated only in IDLE.
- Internal start_s drives as_br start_i. It is registered, high for exactly one cycle, in the cycle after edge detection. as_br br2_o is the only sampling strobe (br2_s); br_o is left unused.
- FSM states and transitions:
  - IDLE: on falling edge, set start_s=1 and go to START.
  - START: on br2_s, go to DATA with bit_cnt=0 if rxd_s==0. Otherwise the edge was a glitch: go to IDLE with nothing delivered.
  - DATA: on br2_s, shreg <= {rxd_s, shreg[7:1]} and bit_cnt++. Go to STOP when bit_cnt reaches 7, i.e. after the 8th sample.
  - STOP: on br2_s, data_o <= shreg, valid_o <= 1 and fe_o <= ~rxd_s. Then go to IDLE.
- Overrun: set ov_o at delivery if valid_o==1 and rd_i==0. The new byte overwrites data_o.
- rd_i while valid_o==1: valid_o, fe_o and ov_o clear next cycle. rd_i while valid_o==0 has no effect.
- rd_i in the same cycle as delivery: the new byte loads, valid_o stays 1, ov_o is not set, and fe_o reflects the new byte.
- Break (line held low): frame ends with fe_o=1. No new frame starts until the line returns high and falls again, because edge detection needs rxd_d==1.
- bit_cnt is 3 bits and never wraps beyond 7 within a frame.

## Timing
- All outputs reset to 0 and the FSM to IDLE; reset mid-frame aborts the frame with no delivery.
- rxd_i fall → edge detected 2–3 clk later → start_s 1 clk later → as_br counter at 0.
- First br2_s occurs br2_cnt_max cycles after the counter restarts (mid start bit). Each subsequent br2_s follows br_cnt_max+1 cycles later (mid of each bit).
- valid_o rises 1 clk after the mid-stop br2_s, about 9.5 bit times after the start edge.
- Back-to-back frames are accepted: the FSM is in IDLE from mid stop bit, so the next start edge is detected.

## Structure
- as_pack holds br_cnt_max, br2_cnt_max, uart_data_bits and typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t.
- Single sub-module: as_br, instantiated internally (start_i ← start_s, br2_o → br2_s, br_o open).
- Synchroniser, edge detect, FSM, shift register and holding register stay in as_uart_rx.

## Test plan
Bench as_pack values: br_cnt_max=9, br2_cnt_max=4 (10 clk/bit).
- Frame 0xA5, stop=1 → one start_s pulse; valid_o=1, data_o=0xA5, fe_o=0, ov_o=0; busy_o low after mid stop.
- rxd_i low for 3 clk, then high → start_s pulses; FSM returns to IDLE at first br2_s; valid_o stays 0.
- Frame 0x3C with stop=0 → data_o=0x3C, valid_o=1, fe_o=1; rd_i → all three clear next clk.
- Frames 0x11 then 0x22, no rd_i → data_o=0x22, ov_o=1; rd_i → valid_o=0, ov_o=0.
- Frames 0x11 then 0x22, rd_i pulsed in the delivery cycle of 0x22 → data_o=0x22, valid_o=1, ov_o=0.
- rst_i asserted during bit 4 of 0xFF → outputs 0 and FSM in IDLE; next frame 0x5A → data_o=0x5A, fe_o=0.
